// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered read, read-valid strobe and selectable read-during-write.
// Define RAM_SYNC_INIT_EN to add the post-reset zero-fill sequencer that clears every word after each reset.
module ram_sync_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int RD_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg;
    logic [ADDR_W-1:0] fill_reg;
    logic              access;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

`ifdef RAM_SYNC_INIT_EN
    state_t            state_next;
    logic [ADDR_W-1:0] fill_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= INIT;
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fill_reg  <= fill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fill_next  = fill_reg;
        if (state_reg == INIT) begin
            fill_next = fill_reg + 1'b1;
            if (fill_reg == ADDR_W'(DEPTH - 1)) begin
                state_next = RUN;
            end
        end
    end

    // busy is taken straight from the state flop, so it is registered.
    assign busy = (state_reg == INIT);
`else
    assign state_reg = RUN;
    assign fill_reg  = '0;
    assign busy      = 1'b0;
`endif

    // The sweep borrows the single write port; user requests only get it in RUN.
    always_comb begin
        access  = (state_reg == RUN) && en;
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = data_in;
        if (state_reg == INIT) begin
            wr_en   = !rst;
            wr_addr = fill_reg;
            wr_data = '0;
        end else begin
            wr_en = access && we && !rst;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= access;
            if (access) begin
                if (we && (RD_MODE == 1)) begin
                    data_out <= data_in;
                end else begin
                    data_out <= mem[addr];
                end
            end
        end
    end

endmodule

// File: doc/ram_sync_param.md
# ram_sync_param

Parametrised single-port synchronous RAM. Successor to the fixed 16x8 synchronous RAM; adds configurable width and depth, an explicit access enable, a read-valid strobe and a selectable read-during-write mode. Adds a post-reset zero-fill sequencer so contents are defined after every reset. Sits as the generic scratch/buffer memory behind the team's datapath blocks.

## Interface
- DATA_W, 8, word width in bits (>=1)
- ADDR_W, 4, address width; depth = 2^ADDR_W words
- RD_MODE, 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  access request, sampled at posedge
- we  in  1  1 = write, 0 = read; meaningful only with en=1
- addr  in  ADDR_W  word address; full range valid, no wrap logic needed
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: data_out updated by an accepted access
- busy  out  1  zero-fill in progress; requests ignored while high

## Operation
- Reset values: data_out=0, rd_valid=0, busy=1 (0 if RAM_SYNC_INIT_EN undefined), fill counter=0, FSM=INIT.
- FSM states: INIT, RUN.
- INIT: each posedge writes 0 to mem[fill counter], then increments the counter. Leaves for RUN after the write to address 2^ADDR_W-1. en/we/addr/data_in ignored. rd_valid stays 0 and data_out holds 0.
- RUN, en=1, we=0: data_out <= mem[addr]; rd_valid=1.
- RUN, en=1, we=1: mem[addr] <= data_in; rd_valid=1. data_out <= old mem[addr] if RD_MODE=0, data_in if RD_MODE=1.
- RUN, en=0: no write; data_out holds its value; rd_valid=0.
- Back-to-back accesses are legal on every cycle with no bubbles.
- rst asserted mid-sweep or mid-access forces the reset values immediately. The sweep restarts at address 0 after deassert. Memory array contents are not reset asynchronously; the sweep is the only clear mechanism.

## Timing
- Read/write latency 1 cycle: request sampled at edge N; data_out and rd_valid valid after edge N and held until edge N+1.
- rd_valid is high for exactly one cycle per accepted access.
- Sweep: edge k (k=1..2^ADDR_W) after rst falls writes address k-1. busy falls at edge 2^ADDR_W. First accepted request is sampled at edge 2^ADDR_W+1.
- busy, rd_valid and data_out are all registered; no combinational path from inputs to outputs.

## Configuration
- RAM_SYNC_INIT_EN defined: INIT state and fill counter present; behaviour as above; busy high for 2^ADDR_W cycles after every reset.
- RAM_SYNC_INIT_EN undefined: no sequencer; FSM reset state is RUN; busy tied 0. Requests are accepted from the first posedge after rst falls. Contents are undefined (X) until written.

## Test plan
- DATA_W=8, ADDR_W=4, INIT_EN on: release rst, then count cycles -> busy high exactly 16 cycles; reads of addresses 0..15 then return 0 with rd_valid=1.
- Write 55, 99, 150, 200, 77 to addresses 0..4 on consecutive cycles, then read 0..4 back-to-back -> data_out 55, 99, 150, 200, 77 on consecutive cycles, rd_valid continuously high.
- RD_MODE=0: mem[3]=200, write 17 to address 3 -> data_out=200; next read of address 3 -> 17. Repeat with RD_MODE=1 -> data_out=17 on the write cycle.
- Read address 1 (value 99), then hold en=0 for 3 cycles with addr changing -> data_out stays 99, rd_valid=0.
- Assert rst while the fill counter is at 9 -> outputs return to reset values at once; after release, busy high a full 16 cycles, and all addresses read 0.
- INIT_EN off, DATA_W=16, ADDR_W=6: write 0xBEEF to address 63 on the first edge after reset, read it back -> 0xBEEF; busy never asserts.
